// File: rtl/ndemux12_buf.sv
// Registered 1-to-2 demultiplexer with a one-entry valid/ready holding register per channel.
// Optional per-channel delivered-word counters are compiled in with NDEMUX12_BUF_STATS_EN.
module ndemux12_buf #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] a,
    input  logic         s,
    input  logic         a_valid,
    output logic         a_ready,
    output logic [N-1:0] z0,
    output logic         z0_valid,
    input  logic         z0_ready,
    output logic [N-1:0] z1,
    output logic         z1_valid,
    input  logic         z1_ready
`ifdef NDEMUX12_BUF_STATS_EN
    ,
    output logic [15:0]  cnt0,
    output logic [15:0]  cnt1
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

    chan_state_t  state [2];
    logic [N-1:0] data  [2];
    logic [1:0]   pop;
    logic [1:0]   push;

    assign pop[0] = (state[0] == FULL) & z0_ready;
    assign pop[1] = (state[1] == FULL) & z1_ready;

    // A full channel can still accept when it drains in the same cycle.
    always_comb begin
        a_ready = 1'b0;
        push    = '0;
        if (s) begin
            a_ready = (state[1] == EMPTY) | pop[1];
        end else begin
            a_ready = (state[0] == EMPTY) | pop[0];
        end
        push[0] = a_valid & a_ready & ~s;
        push[1] = a_valid & a_ready & s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < 2; k++) begin
                state[k] <= EMPTY;
                data[k]  <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < 2; k++) begin
                case (state[k])
                    EMPTY: begin
                        if (push[k]) begin
                            state[k] <= FULL;
                            data[k]  <= a;
                        end
                    end
                    FULL: begin
                        if (push[k]) begin
                            data[k] <= a;
                        end else if (pop[k]) begin
                            state[k] <= EMPTY;
                        end
                    end
                    default: state[k] <= EMPTY;
                endcase
            end
        end
    end

    assign z0       = data[0];
    assign z1       = data[1];
    assign z0_valid = (state[0] == FULL);
    assign z1_valid = (state[1] == FULL);

`ifdef NDEMUX12_BUF_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (pop[0]) cnt0 <= cnt0 + 16'd1;
            if (pop[1]) cnt1 <= cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ndemux12_buf.sv
// Self-checking bench for ndemux12_buf: a queue-based channel model scores randomized and directed traffic.
// Counter checks are compiled in when NDEMUX12_BUF_STATS_EN is defined.
module tb_ndemux12_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a = '0;
    logic        s = 1'b0;
    logic        a_valid = 1'b0;
    logic        a_ready;
    logic [31:0] z0, z1;
    logic        z0_valid, z1_valid;
    logic        z0_ready = 1'b0;
    logic        z1_ready = 1'b0;
`ifdef NDEMUX12_BUF_STATS_EN
    logic [15:0] cnt0, cnt1;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: each channel is a queue of words awaiting delivery (capacity one).
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    logic [15:0] mcnt0 = '0;
    logic [15:0] mcnt1 = '0;
    int          pops0 = 0;

    ndemux12_buf #(.N(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a        (a),
        .s        (s),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .z0       (z0),
        .z0_valid (z0_valid),
        .z0_ready (z0_ready),
        .z1       (z1),
        .z1_valid (z1_valid),
        .z1_ready (z1_ready)
`ifdef NDEMUX12_BUF_STATS_EN
        ,
        .cnt0     (cnt0),
        .cnt1     (cnt1)
`endif
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        q0.delete();
        q1.delete();
        last0 = '0;
        last1 = '0;
        mcnt0 = '0;
        mcnt1 = '0;
    endfunction

    // Drive one cycle, compare every visible output against the model, then advance the model.
    task automatic cycle(input logic v, input logic sel, input logic [31:0] d,
                         input logic r0, input logic r1);
        logic        e_v0, e_v1, e_rdy;
        logic [31:0] e_z0, e_z1;
        @(negedge clk);
        a_valid = v; s = sel; a = d; z0_ready = r0; z1_ready = r1;
        #1;
        e_v0  = (q0.size() != 0);
        e_v1  = (q1.size() != 0);
        e_z0  = e_v0 ? q0[0] : last0;
        e_z1  = e_v1 ? q1[0] : last1;
        e_rdy = sel ? (!e_v1 || r1) : (!e_v0 || r0);
        tests++; if (z0_valid !== e_v0) begin fails++; $display("FAIL z0_valid got=%b exp=%b t=%0t", z0_valid, e_v0, $time); end
        tests++; if (z1_valid !== e_v1) begin fails++; $display("FAIL z1_valid got=%b exp=%b t=%0t", z1_valid, e_v1, $time); end
        tests++; if (z0 !== e_z0) begin fails++; $display("FAIL z0 got=%h exp=%h t=%0t", z0, e_z0, $time); end
        tests++; if (z1 !== e_z1) begin fails++; $display("FAIL z1 got=%h exp=%h t=%0t", z1, e_z1, $time); end
        tests++; if (a_ready !== e_rdy) begin fails++; $display("FAIL a_ready got=%b exp=%b t=%0t", a_ready, e_rdy, $time); end
`ifdef NDEMUX12_BUF_STATS_EN
        tests++; if (cnt0 !== mcnt0) begin fails++; $display("FAIL cnt0 got=%0d exp=%0d t=%0t", cnt0, mcnt0, $time); end
        tests++; if (cnt1 !== mcnt1) begin fails++; $display("FAIL cnt1 got=%0d exp=%0d t=%0t", cnt1, mcnt1, $time); end
`endif
        if (e_v0 && r0) begin last0 = q0.pop_front(); mcnt0 = mcnt0 + 16'd1; pops0++; end
        if (e_v1 && r1) begin last1 = q1.pop_front(); mcnt1 = mcnt1 + 16'd1; end
        if (v && e_rdy) begin
            if (sel) q1.push_back(d); else q0.push_back(d);
        end
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_valid = 1'b0;
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        a_valid = 1'b1; s = 1'($urandom); a = $urandom; z0_ready = 1'b1; z1_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        tests++; if (z0_valid !== 1'b0 || z1_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b%b exp=00", z0_valid, z1_valid); end
        tests++; if (z0 !== 32'h0 || z1 !== 32'h0) begin fails++; $display("FAIL reset_data got=%h/%h exp=0/0", z0, z1); end
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL reset_a_ready got=%b exp=1", a_ready); end
`ifdef NDEMUX12_BUF_STATS_EN
        tests++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin fails++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
`endif
        a_valid = 1'b0;
        rst_n = 1'b1;
        model_reset();
        cycle(1'b1, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_basic_routing();
        do_reset();
        cycle(1'b1, 1'b0, 32'hAAAAAAAA, 1'b1, 1'b1);
        cycle(1'b1, 1'b1, 32'hBBBBBBBB, 1'b1, 1'b1);
        #1;
        tests++; if (z1 !== 32'hBBBBBBBB || z1_valid !== 1'b1) begin fails++; $display("FAIL route_z1 got=%h/%b exp=bbbbbbbb/1", z1, z1_valid); end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_backpressure();
        do_reset();
        cycle(1'b1, 1'b0, 32'hCAFE0001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, $urandom, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'h12345678, 1'b0, 1'b0);
        #1;
        tests++; if (z1 !== 32'h12345678 || z1_valid !== 1'b1) begin fails++; $display("FAIL bp_z1 got=%h/%b exp=12345678/1", z1, z1_valid); end
        tests++; if (z0 !== 32'hCAFE0001) begin fails++; $display("FAIL bp_z0_stable got=%h exp=cafe0001", z0); end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_streaming();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
            #1;
            tests++; if (z0 !== 32'(i) || z0_valid !== 1'b1) begin fails++; $display("FAIL stream_z0 got=%h/%b exp=%h/1", z0, z0_valid, 32'(i)); end
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1'b1, 1'b0, 32'h0F0F0F0F, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 32'hF0F0F0F0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++; if (z0_valid !== 1'b0 || z1_valid !== 1'b0) begin fails++; $display("FAIL async_valid got=%b%b exp=00", z0_valid, z1_valid); end
        tests++; if (z0 !== 32'h0 || z1 !== 32'h0) begin fails++; $display("FAIL async_data got=%h/%h exp=0/0", z0, z1); end
`ifdef NDEMUX12_BUF_STATS_EN
        tests++; if (cnt0 !== 16'h0 || cnt1 !== 16'h0) begin fails++; $display("FAIL async_cnt got=%0d/%0d exp=0/0", cnt0, cnt1); end
`endif
        model_reset();
        a_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef NDEMUX12_BUF_STATS_EN
    task automatic test_stats_wrap();
        do_reset();
        pops0 = 0;
        for (int i = 0; i < 70000 && pops0 < 65537; i++)
            cycle(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
        tests++; if (pops0 != 65537) begin fails++; $display("FAIL wrap_budget got=%0d exp=65537", pops0); end
        @(negedge clk); #1;
        tests++; if (cnt0 !== 16'd1) begin fails++; $display("FAIL wrap_cnt0 got=%0d exp=1", cnt0); end
        tests++; if (cnt1 !== 16'd0) begin fails++; $display("FAIL wrap_cnt1 got=%0d exp=0", cnt1); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_streaming();
        test_random();
        test_async_reset();
`ifdef NDEMUX12_BUF_STATS_EN
        test_stats_wrap();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ndemux12_buf.md
# ndemux12_buf

Registered 1-to-2 demultiplexer with a valid/ready handshake on every channel: one N-bit input word plus a select bit is steered to output channel 0 or 1, each backed by a one-entry holding register. It is the steering counterpart of the N-bit 2:1 mux in the basic-circuits library. It sits between a single producer (e.g. a writeback or forwarding bus) and two independent consumers (e.g. two core-side ports) that may stall separately.

## Interface
- N, default 32: data width in bits (N >= 1).
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- a  in  N  input data word.
- s  in  1  select: 0 routes to channel 0, 1 routes to channel 1.
- a_valid  in  1  input word and select are valid this cycle.
- a_ready  out  1  block accepts the input this cycle.
- z0  out  N  channel-0 data.
- z0_valid  out  1  channel-0 holds a word.
- z0_ready  in  1  channel-0 consumer takes the word this cycle.
- z1, z1_valid, z1_ready: same as channel 0, for channel 1.
- Compiled in only with NDEMUX12_BUF_STATS_EN: cnt0, cnt1  out  16  per-channel count of delivered words.

## Operation
- One holding register per channel: data[k] (N bits) and full[k] (1 bit). zk = data[k]; zk_valid = full[k].
- Per-channel state: EMPTY (full=0) or FULL (full=1).
- Drain: pop[k] = full[k] & zk_ready.
- Accept: a_ready = ~full[s] | pop[s]. a_ready depends combinationally on s and on the selected channel's ready. push = a_valid & a_ready, and it targets channel s only.
- Transitions per channel k:
  - EMPTY + push to k -> FULL; data[k] <= a.
  - FULL + pop[k], no push to k -> EMPTY; data[k] is held, not cleared.
  - FULL + pop[k] + push to k -> stays FULL; data[k] <= a. This is back-to-back throughput.
  - FULL, no pop[k] -> FULL, data held. Push to k is impossible because a_ready=0 for s=k.
- Channels are independent. A stalled channel never blocks input selecting the other channel.
- Output stability: while zk_valid=1 and zk_ready=0, zk must not change.
- Input ordering: words to the same channel are delivered in acceptance order. No ordering is defined across channels.
- a and s are ignored when a_valid=0. A word is never duplicated and never dropped.

## Timing
- Reset (rst_n=0, asynchronous): full[0]=full[1]=0, data[0]=data[1]=0, z0=z1=0, z0_valid=z1_valid=0, cnt0=cnt1=0. a_ready is 1 during and after reset, since both channels are empty.
- Reset asserted mid-operation discards any buffered words immediately, without waiting for a clock edge.
- Latency: a word accepted at edge t is presented on zk with zk_valid=1 after edge t. That is 1 cycle, with no combinational a->zk path.
- Throughput: one word per cycle per channel when the consumer holds zk_ready=1. Combined throughput is up to 1 word per cycle, since there is a single input.
- Deassertion of rst_n is followed by normal operation on the next rising edge.

## Configuration
- NDEMUX12_BUF_STATS_EN defined:
  - Ports cnt0 and cnt1 exist.
  - cntk increments by 1 on every cycle with pop[k]=1.
  - Counters wrap modulo 2^16 (16'hFFFF -> 16'h0000).
  - Counters are cleared only by reset.
- NDEMUX12_BUF_STATS_EN undefined: cnt0/cnt1 ports and their logic are absent. Datapath behaviour is identical to the defined case.

## Test plan
- Reset: hold rst_n=0 with a_valid=1 -> z0_valid=z1_valid=0, z0=z1=0, a_ready=1. Release reset -> first push behaves normally.
- Basic routing: a=32'hAAAAAAAA, s=0, a_valid=1 for one cycle, z0_ready=1 -> next cycle z0=32'hAAAAAAAA, z0_valid=1, z1_valid=0. Then a=32'hBBBBBBBB, s=1 -> z1=32'hBBBBBBBB, z1_valid=1.
- Backpressure isolation: fill channel 0, hold z0_ready=0, present s=0 -> a_ready=0 and z0 stays stable. Present s=1, a=32'h12345678 -> a_ready=1 and z1=32'h12345678 the next cycle.
- Streaming: z0_ready=1 constantly, push 8 words 1..8 on consecutive cycles with s=0 -> a_ready=1 every cycle and z0 shows 1..8 on consecutive cycles.
- Async reset mid-flight: both channels FULL, drop rst_n between clock edges -> both valids fall immediately, before the next edge. With STATS_EN, cnt0=cnt1=0.
- STATS_EN wrap: drain 65537 words on channel 0 -> cnt0=1, cnt1=0.
